// File: rtl/epcs_page_cache.sv
// ---------------------------------------------------------------------------
// epcs_page_cache
//
// Read cache in front of an EPCS-style serial flash page reader. It holds
// WAYS whole pages of 2^PAGE_W bytes. Lookups run only in IDLE. A miss evicts
// the least recently used way and refills it over the shared flash bus, one
// byte at a time.
//
// Ports
//   nReset          async active-low reset
//   Clk             clock (<= 40 MHz)
//   Address         requested byte address
//   Data            registered cached byte
//   Data_Valid      Data belongs to the current Address
//   Invalidate      one-cycle pulse that flushes every way
//   Mutex_Request   flash bus request, held from REQ through FILL_WR
//   Mutex_Grant     flash bus granted
//   Flash_Page      page number being fetched (the victim tag)
//   Flash_ReadPage  page read command, held until Flash_Busy rises
//   Flash_Busy      flash controller busy
//   Flash_Address   byte index into the flash page buffer
//   Flash_DataOut   byte at Flash_Address, valid one cycle after it changes
// ---------------------------------------------------------------------------

// One cache way: tag, valid bit and the hit compare.
//   lookup_tag_i  tag of the current Address
//   new_tag_i     tag loaded when this way becomes the victim
//   tag_wr_i      load new_tag_i; this also clears valid
//   set_valid_i   fill finished cleanly
//   clr_valid_i   flush; wins over set_valid_i
//   hit_o         valid way whose tag matches lookup_tag_i
module epcs_page_cache_way #(
    parameter int TAG_W = 13
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic [TAG_W-1:0] lookup_tag_i,
    input  logic [TAG_W-1:0] new_tag_i,
    input  logic             tag_wr_i,
    input  logic             set_valid_i,
    input  logic             clr_valid_i,
    output logic             hit_o
);
    logic [TAG_W-1:0] tag_q;
    logic             valid_q;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (tag_wr_i)
                tag_q <= new_tag_i;
            if (clr_valid_i || tag_wr_i)
                valid_q <= 1'b0;
            else if (set_valid_i)
                valid_q <= 1'b1;
        end
    end

    assign hit_o = valid_q && (tag_q == lookup_tag_i);
endmodule

module epcs_page_cache #(
    parameter int WAYS   = 4,
    parameter int ADDR_W = 21,
    parameter int PAGE_W = 8
) (
    input  logic                     nReset,
    input  logic                     Clk,
    input  logic [ADDR_W-1:0]        Address,
    output logic [7:0]               Data,
    output logic                     Data_Valid,
    input  logic                     Invalidate,
    output logic                     Mutex_Request,
    input  logic                     Mutex_Grant,
    output logic [ADDR_W-PAGE_W-1:0] Flash_Page,
    output logic                     Flash_ReadPage,
    input  logic                     Flash_Busy,
    output logic [PAGE_W-1:0]        Flash_Address,
    input  logic [7:0]               Flash_DataOut
);
    localparam int TAG_W      = ADDR_W - PAGE_W;
    localparam int WB         = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PAGE_BYTES = 1 << PAGE_W;

    typedef enum logic [2:0] {
        IDLE, REQ, START, WAIT_BUSY, WAIT_DONE, FILL_ADDR, FILL_WR
    } state_t;

    state_t                      state_q, state_d;
    logic [WAYS-1:0][WB-1:0]     lru_q, lru_d;     // [0] = MRU, [WAYS-1] = LRU
    logic [WB-1:0]               victim_q, victim_d;
    logic [TAG_W-1:0]            page_q, page_d;
    logic [PAGE_W-1:0]           faddr_q, faddr_d;
    logic [7:0]                  data_q, data_d;
    logic                        dv_q, dv_d;
    logic                        pend_q, pend_d;   // flush arrived mid-fill
    logic [ADDR_W-1:0]           addr_q;

    // Page storage, one page per way. No reset: contents are meaningless
    // until the matching valid bit is set.
    logic [7:0]                  ram_q [0:WAYS*PAGE_BYTES-1];
    logic                        ram_we;

    logic [TAG_W-1:0]            tag_in;
    logic [WAYS-1:0]             hit_vec;
    logic [WAYS-1:0]             tag_wr;
    logic [WAYS-1:0]             set_valid;
    logic                        hit_any;
    logic [WB-1:0]               hit_pos;          // LRU position of the hit way
    logic                        promote;
    logic [WB-1:0]               promote_pos;

    assign tag_in = Address[ADDR_W-1:PAGE_W];

    // ---------------- per-way tag/valid ----------------
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        epcs_page_cache_way #(.TAG_W(TAG_W)) u_way (
            .Clk          (Clk),
            .nReset       (nReset),
            .lookup_tag_i (tag_in),
            .new_tag_i    (tag_in),
            .tag_wr_i     (tag_wr[w]),
            .set_valid_i  (set_valid[w]),
            .clr_valid_i  (Invalidate),
            .hit_o        (hit_vec[w])
        );
    end

    assign hit_any = |hit_vec;

    // Walk the LRU list so that the hit is reported as a list position. That
    // position is what the reorder needs, and position 0 means an MRU hit.
    always_comb begin
        hit_pos = '0;
        for (int i = WAYS - 1; i >= 0; i--)
            if (hit_vec[lru_q[i]])
                hit_pos = WB'(i);
    end

    // ---------------- next state / outputs ----------------
    always_comb begin
        state_d        = state_q;
        lru_d          = lru_q;
        victim_d       = victim_q;
        page_d         = page_q;
        faddr_d        = faddr_q;
        data_d         = data_q;
        dv_d           = 1'b0;
        pend_d         = pend_q;
        tag_wr         = '0;
        set_valid      = '0;
        ram_we         = 1'b0;
        promote        = 1'b0;
        promote_pos    = '0;
        Mutex_Request  = 1'b0;
        Flash_ReadPage = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Invalidate) begin
                    dv_d = 1'b0;
                end else if (hit_any) begin
                    if (hit_pos == '0) begin
                        dv_d   = 1'b1;
                        data_d = ram_q[{lru_q[0], Address[PAGE_W-1:0]}];
                    end else begin
                        // Reorder this cycle. Data follows on the next
                        // cycle, once this way is MRU.
                        promote     = 1'b1;
                        promote_pos = hit_pos;
                    end
                end else begin
                    promote             = 1'b1;
                    promote_pos         = WB'(WAYS - 1);
                    victim_d            = lru_q[WAYS-1];
                    tag_wr[lru_q[WAYS-1]] = 1'b1;
                    page_d              = tag_in;
                    faddr_d             = '0;
                    state_d             = REQ;
                end
            end
            REQ: begin
                Mutex_Request = 1'b1;
                faddr_d       = '0;
                if (Mutex_Grant)
                    state_d = START;
            end
            START: begin
                Mutex_Request  = 1'b1;
                Flash_ReadPage = 1'b1;
                if (Flash_Busy)
                    state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                Mutex_Request = 1'b1;
                if (!Flash_Busy)
                    state_d = FILL_ADDR;
            end
            // The flash buffer needs one cycle after an address change.
            FILL_ADDR: begin
                Mutex_Request = 1'b1;
                state_d       = FILL_WR;
            end
            FILL_WR: begin
                Mutex_Request = 1'b1;
                ram_we        = 1'b1;
                faddr_d       = faddr_q + 1'b1;
                state_d       = (faddr_q == '1) ? WAIT_DONE : FILL_ADDR;
            end
            WAIT_DONE: begin
                // A flush that arrived during the fill, or one arriving now,
                // leaves the victim invalid.
                if (!pend_q && !Invalidate)
                    set_valid[victim_q] = 1'b1;
                pend_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (Invalidate && state_q != IDLE && state_q != WAIT_DONE)
            pend_d = 1'b1;

        // Move the entry at promote_pos to the front and shift the entries
        // above it down by one.
        if (promote) begin
            lru_d[0] = lru_q[promote_pos];
            for (int i = 1; i < WAYS; i++)
                if (WB'(i) <= promote_pos)
                    lru_d[i] = lru_q[i-1];
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= IDLE;
            for (int i = 0; i < WAYS; i++)
                lru_q[i] <= WB'(i);
            victim_q <= '0;
            page_q   <= '0;
            faddr_q  <= '0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            pend_q   <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            lru_q    <= lru_d;
            victim_q <= victim_d;
            page_q   <= page_d;
            faddr_q  <= faddr_d;
            data_q   <= data_d;
            dv_q     <= dv_d;
            pend_q   <= pend_d;
            addr_q   <= Address;
        end
    end

    always_ff @(posedge Clk) begin
        if (ram_we)
            ram_q[{victim_q, faddr_q}] <= Flash_DataOut;
    end

    assign Data          = data_q;
    assign Flash_Page    = page_q;
    assign Flash_Address = faddr_q;
    // Drop valid as soon as Address moves. The registered byte then belongs
    // to the previous address.
    assign Data_Valid    = dv_q && (state_q == IDLE) && (Address == addr_q);
endmodule

// File: tb/tb_epcs_page_cache.sv
module tb_epcs_page_cache;
    localparam int WAYS   = 4;
    localparam int ADDR_W = 21;
    localparam int PAGE_W = 8;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic [20:0] Address = 21'h000123;
    logic [7:0]  Data;
    logic        Data_Valid;
    logic        Invalidate = 1'b0;
    logic        Mutex_Request;
    logic        Mutex_Grant = 1'b0;
    logic [12:0] Flash_Page;
    logic        Flash_ReadPage;
    logic        Flash_Busy = 1'b0;
    logic [7:0]  Flash_Address;
    logic [7:0]  Flash_DataOut = 8'h00;

    int checks = 0;
    int failures = 0;

    epcs_page_cache #(.WAYS(WAYS), .ADDR_W(ADDR_W), .PAGE_W(PAGE_W)) dut (
        .nReset         (nReset),
        .Clk            (Clk),
        .Address        (Address),
        .Data           (Data),
        .Data_Valid     (Data_Valid),
        .Invalidate     (Invalidate),
        .Mutex_Request  (Mutex_Request),
        .Mutex_Grant    (Mutex_Grant),
        .Flash_Page     (Flash_Page),
        .Flash_ReadPage (Flash_ReadPage),
        .Flash_Busy     (Flash_Busy),
        .Flash_Address  (Flash_Address),
        .Flash_DataOut  (Flash_DataOut)
    );

    always #5 Clk = ~Clk;

    // Flash page contents: a simple pattern that differs per page and per byte.
    function automatic logic [7:0] fdat(input logic [12:0] pg, input logic [7:0] idx);
        logic [7:0] p;
        p = pg[7:0];
        return idx ^ (p * 8'd37) ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Flash controller and bus arbiter model. It updates 1 ns after each edge.
    // Flash_DataOut follows Flash_Address with one cycle of lag.
    logic        grant_en = 1'b1;
    int          fills = 0;
    int          bcnt = 0;
    logic        req_prev = 1'b0;
    logic [12:0] fpage = '0;
    logic [7:0]  faddr_seen = '0;

    always @(posedge Clk) begin
        #1;
        Mutex_Grant = grant_en && Mutex_Request;
        if (!nReset) begin
            Flash_Busy = 1'b0;
            bcnt       = 0;
            req_prev   = 1'b0;
        end else begin
            if (Mutex_Request && !req_prev)
                fills++;
            req_prev = Mutex_Request;
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0)
                    Flash_Busy = 1'b0;
            end else if (Flash_ReadPage && !Flash_Busy) begin
                fpage      = Flash_Page;
                Flash_Busy = 1'b1;
                bcnt       = 5;
            end
            Flash_DataOut = fdat(fpage, faddr_seen);
            faddr_seen    = Flash_Address;
        end
    end

    task automatic tick;
        @(posedge Clk);
        #2;
    endtask

    task automatic access(input logic [20:0] a, input int exp_fill, input string tag);
        int f0;
        int n;
        f0 = fills;
        Address = a;
        n = 0;
        do begin
            tick;
            n++;
        end while (!Data_Valid && n < 3000);
        chk({tag, "_timeout"}, 32'(n < 3000), 32'd1);
        chk({tag, "_data"}, 32'(Data), 32'(fdat(a[20:8], a[7:0])));
        chk({tag, "_fills"}, fills - f0, exp_fill);
    endtask

    initial begin
        int n;
        int f0;
        int bad;

        // Reset state. Address is already non-zero, on page 1.
        #12;
        chk("rst_dv",    32'(Data_Valid), 0);
        chk("rst_mreq",  32'(Mutex_Request), 0);
        chk("rst_rdpg",  32'(Flash_ReadPage), 0);
        chk("rst_faddr", 32'(Flash_Address), 0);
        chk("rst_page",  32'(Flash_Page), 0);
        chk("rst_data",  32'(Data), 0);
        @(posedge Clk);
        #2;
        nReset = 1'b1;

        // Cold start, page 1. The first lookup must miss.
        f0 = fills;
        tick;
        chk("cold_mreq", 32'(Mutex_Request), 1);
        chk("cold_page", 32'(Flash_Page), 32'h1);
        chk("cold_dv",   32'(Data_Valid), 0);
        chk("cold_rdpg", 32'(Flash_ReadPage), 0);
        n = 0;
        while (!Data_Valid && n < 3000) begin
            tick;
            n++;
        end
        chk("cold_timeout", 32'(n < 3000), 1);
        chk("cold_len",     32'(n >= 512), 1);
        chk("cold_data",    32'(Data), 32'(fdat(13'h1, 8'h23)));
        chk("cold_fills",   fills - f0, 1);

        // Hit latency within page 1. Valid drops for one cycle, then data.
        Address = 21'h0001FF;
        #1;
        chk("hl_dv0_a", 32'(Data_Valid), 0);
        tick;
        chk("hl_dv1_a", 32'(Data_Valid), 1);
        chk("hl_d_a",   32'(Data), 32'(fdat(13'h1, 8'hFF)));
        Address = 21'h000100;
        #1;
        chk("hl_dv0_b", 32'(Data_Valid), 0);
        tick;
        chk("hl_dv1_b", 32'(Data_Valid), 1);
        chk("hl_d_b",   32'(Data), 32'(fdat(13'h1, 8'h00)));

        // LRU. Pages 1..4 are resident, page 1 is touched, so page 5 evicts 2.
        access(21'h000200, 1, "p2");
        access(21'h000305, 1, "p3");
        access(21'h0004AA, 1, "p4");
        access(21'h000110, 0, "t1");
        access(21'h0005C3, 1, "p5");
        access(21'h0001EE, 0, "h1");
        access(21'h000377, 0, "h3");
        access(21'h000488, 0, "h4");
        access(21'h000201, 1, "ev2");

        // A non-MRU hit (page 3) spends one cycle reordering with no valid
        // and no bus request.
        Address = 21'h000311;
        tick;
        chk("nmru_dv0",  32'(Data_Valid), 0);
        chk("nmru_mreq", 32'(Mutex_Request), 0);
        tick;
        chk("nmru_dv1",  32'(Data_Valid), 1);
        chk("nmru_data", 32'(Data), 32'(fdat(13'h3, 8'h11)));

        // Invalidate during the fill of page 7. The fill completes, then
        // page 7 is fetched a second time.
        f0 = fills;
        Address = 21'h0007AB;
        n = 0;
        while (Flash_Address != 8'h20 && n < 2000) begin
            tick;
            n++;
        end
        chk("inv_reach", 32'(n < 2000), 1);
        Invalidate = 1'b1;
        tick;
        Invalidate = 1'b0;
        n = 0;
        while (Mutex_Request && n < 2000) begin
            tick;
            n++;
        end
        chk("inv_drop",   32'(n < 2000), 1);
        chk("inv_fills1", fills - f0, 1);
        n = 0;
        while (!Data_Valid && n < 3000) begin
            tick;
            n++;
        end
        chk("inv_timeout", 32'(n < 3000), 1);
        chk("inv_fills2",  fills - f0, 2);
        chk("inv_data",    32'(Data), 32'(fdat(13'h7, 8'hAB)));

        // Invalidate in IDLE while page 7 is valid.
        Invalidate = 1'b1;
        tick;
        Invalidate = 1'b0;
        chk("invi_dv",   32'(Data_Valid), 0);
        chk("invi_mreq", 32'(Mutex_Request), 0);
        access(21'h0007AB, 1, "invi_refill");
        access(21'h000123, 1, "inv_p1");

        // Grant withheld for 100 cycles.
        grant_en = 1'b0;
        Address = 21'h0009C4;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (!Mutex_Request || Flash_ReadPage || Data_Valid)
                bad++;
        end
        chk("gnt_hold", bad, 0);
        grant_en = 1'b1;
        access(21'h0009C4, 0, "gnt_fill");

        // Reset pulsed in FILL_WR.
        Address = 21'h000A10;
        n = 0;
        while (Flash_Address != 8'h40 && n < 2000) begin
            tick;
            n++;
        end
        chk("rfw_reach", 32'(n < 2000), 1);
        tick;
        #1;
        nReset = 1'b0;
        #1;
        chk("rfw_mreq",  32'(Mutex_Request), 0);
        chk("rfw_rdpg",  32'(Flash_ReadPage), 0);
        chk("rfw_faddr", 32'(Flash_Address), 0);
        chk("rfw_dv",    32'(Data_Valid), 0);
        tick;
        nReset = 1'b1;
        access(21'h000A10, 1, "rfw_miss");
        access(21'h000123, 1, "rfw_p1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
